// File: rtl/glyph_rom_arbiter.sv
// glyph_rom_arbiter: shares the registered-read glyph ROM between the display pipeline
// (absolute priority, never stalled) and a single-transaction CPU readback port.
module glyph_rom_arbiter #(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 24,
    parameter int ROM_DEPTH = 2056,
    parameter int TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              cpu_timeout,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  TMO_V   = CNT_W'(TIMEOUT);
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(ROM_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, CAPT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] caddr_q, caddr_d;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;
    logic              dvld_q;
    logic              grant;
    logic              in_range;

    assign in_range = ({1'b0, cpu_addr} < DEPTH_V);

    always_comb begin
        state_d = state_q;
        caddr_d = caddr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        tmo_d   = 1'b0;
        grant   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // err_q marks the busy cycle of a rejected request
                if (cpu_req && !err_q) begin
                    caddr_d = cpu_addr;
                    cnt_d   = '0;
                    if (in_range) state_d = WAIT;
                    else          err_d   = 1'b1;
                end
            end
            WAIT: begin
                // A free slot always beats an expiring counter
                if (!disp_req) begin
                    grant   = 1'b1;
                    state_d = CAPT;
                end else begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    if ((TIMEOUT != 0) && (cnt_d == TMO_V)) begin
                        tmo_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            CAPT: begin
                rdata_d = rom_data;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold the last address when nobody drives the ROM to avoid toggling it
    assign rom_addr    = disp_req ? disp_addr : (grant ? caddr_q : rom_addr_q);
    assign disp_rdata  = rom_data;
    assign disp_rvalid = dvld_q;
    assign cpu_busy    = (state_q != IDLE) || err_q;
    assign cpu_done    = (state_q == CAPT) || err_q || tmo_q;
    assign cpu_err     = err_q;
    assign cpu_timeout = tmo_q;
    assign cpu_rdata   = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            caddr_q    <= '0;
            rom_addr_q <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            dvld_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            caddr_q    <= caddr_d;
            rom_addr_q <= rom_addr;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            dvld_q     <= disp_req;
        end
    end
endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// Directed bench for glyph_rom_arbiter: one instance with the default timeout and one with
// TIMEOUT=8, both fed the same request stimulus, each with its own registered ROM model.
module tb_glyph_rom_arbiter;
    localparam int AW = 17;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;

    logic [DW-1:0] disp_rdata, cpu_rdata;
    logic          disp_rvalid, cpu_busy, cpu_done, cpu_err, cpu_timeout;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;

    logic [DW-1:0] disp_rdata_8, cpu_rdata_8;
    logic          disp_rvalid_8, cpu_busy_8, cpu_done_8, cpu_err_8, cpu_timeout_8;
    logic [AW-1:0] rom_addr_8;
    logic [DW-1:0] rom_data_8 = '0;

    bit ovr = 1'b0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    glyph_rom_arbiter u_dut (
        .clk(clk), .rst_n(rst_n), .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid), .cpu_req(cpu_req),
        .cpu_addr(cpu_addr), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
        .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .cpu_timeout(cpu_timeout),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    glyph_rom_arbiter #(.TIMEOUT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rdata(disp_rdata_8), .disp_rvalid(disp_rvalid_8), .cpu_req(cpu_req),
        .cpu_addr(cpu_addr), .cpu_busy(cpu_busy_8), .cpu_done(cpu_done_8),
        .cpu_rdata(cpu_rdata_8), .cpu_err(cpu_err_8), .cpu_timeout(cpu_timeout_8),
        .rom_addr(rom_addr_8), .rom_data(rom_data_8)
    );

    // ROM contents: addr*3, with 0x10 optionally overridden to 0xABCDEF
    function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = DW'(a);
        if (ovr && a == AW'(16)) return 24'hABCDEF;
        return w * 3;
    endfunction

    always @(posedge clk) rom_data   <= romf(rom_addr);
    always @(posedge clk) rom_data_8 <= romf(rom_addr_8);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          dreq;
        logic [AW-1:0] daddr;
        logic          creq;
        logic [AW-1:0] caddr;
        logic [AW-1:0] e_rom;
        logic          e_dv;
        logic [DW-1:0] e_dd;
        logic          e_busy, e_done, e_err;
        logic [DW-1:0] e_crd;
    } vec_t;

    vec_t tbl[15];

    task automatic sv(input int i, input bit dreq, input int daddr, input bit creq, input int caddr,
                      input int erom, input bit edv, input int edd, input bit eb, input bit ed,
                      input bit ee, input int ecrd);
        tbl[i].dreq = dreq;       tbl[i].daddr = AW'(daddr);
        tbl[i].creq = creq;       tbl[i].caddr = AW'(caddr);
        tbl[i].e_rom = AW'(erom); tbl[i].e_dv = edv;   tbl[i].e_dd = DW'(edd);
        tbl[i].e_busy = eb;       tbl[i].e_done = ed;  tbl[i].e_err = ee;
        tbl[i].e_crd = DW'(ecrd);
    endtask

    task automatic drive(input bit dreq, input int daddr, input bit creq, input int caddr);
        disp_req  = dreq;
        disp_addr = AW'(daddr);
        cpu_req   = creq;
        cpu_addr  = AW'(caddr);
    endtask

    initial begin
        //  i  dreq daddr creq caddr   rom   dv dd    busy done err crdata
        sv( 0, 1, 5,   0, 0,       5,    0, 0,    0, 0, 0, 0);
        sv( 1, 1, 6,   0, 0,       6,    1, 15,   0, 0, 0, 0);
        sv( 2, 0, 7,   0, 0,       6,    1, 18,   0, 0, 0, 0);
        sv( 3, 0, 0,   1, 'h20,    6,    0, 0,    0, 0, 0, 0);
        sv( 4, 0, 0,   0, 0,       'h20, 0, 0,    1, 0, 0, 0);
        sv( 5, 1, 9,   0, 0,       9,    0, 0,    1, 1, 0, 0);
        sv( 6, 0, 0,   0, 0,       9,    1, 27,   0, 0, 0, 'h60);
        sv( 7, 0, 0,   1, 2056,    9,    0, 0,    0, 0, 0, 'h60);
        sv( 8, 0, 0,   1, 'h30,    9,    0, 0,    1, 1, 1, 'h60);
        sv( 9, 0, 0,   0, 0,       9,    0, 0,    0, 0, 0, 'h60);
        sv(10, 1, 100, 1, 2055,    100,  0, 0,    0, 0, 0, 'h60);
        sv(11, 1, 101, 1, 'h40,    101,  1, 300,  1, 0, 0, 'h60);
        sv(12, 0, 0,   0, 0,       2055, 1, 303,  1, 0, 0, 'h60);
        sv(13, 0, 0,   0, 0,       2055, 0, 0,    1, 1, 0, 'h60);
        sv(14, 0, 0,   0, 0,       2055, 0, 0,    0, 0, 0, 6165);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dvalid", 32'(disp_rvalid), 0);
        chk("rst_busy", 32'(cpu_busy), 0);
        chk("rst_done", 32'(cpu_done), 0);
        chk("rst_err", 32'(cpu_err), 0);
        chk("rst_tmo", 32'(cpu_timeout), 0);
        chk("rst_crdata", 32'(cpu_rdata), 0);
        chk("rst_romaddr", 32'(rom_addr), 0);
        chk("rst_busy8", 32'(cpu_busy_8), 0);
        rst_n = 1'b1;

        // Table-driven cycles
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(tbl[i].dreq, int'(tbl[i].daddr), tbl[i].creq, int'(tbl[i].caddr));
            #1;
            chk($sformatf("tbl%0d_rom", i), 32'(rom_addr), 32'(tbl[i].e_rom));
            chk($sformatf("tbl%0d_dv", i), 32'(disp_rvalid), 32'(tbl[i].e_dv));
            if (tbl[i].e_dv) chk($sformatf("tbl%0d_dd", i), 32'(disp_rdata), 32'(tbl[i].e_dd));
            chk($sformatf("tbl%0d_busy", i), 32'(cpu_busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_done", i), 32'(cpu_done), 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d_err", i), 32'(cpu_err), 32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_tmo", i), 32'(cpu_timeout), 0);
            chk($sformatf("tbl%0d_crd", i), 32'(cpu_rdata), 32'(tbl[i].e_crd));
        end

        // Display streaming 0..639 with a pending C request
        for (int c = 0; c <= 642; c++) begin
            @(negedge clk);
            drive(c < 640, (c < 640) ? c : 0, c == 0, 'h100);
            #1;
            if (c < 640) chk($sformatf("strm%0d_rom", c), 32'(rom_addr), 32'(c));
            if (c >= 1 && c <= 640) begin
                chk($sformatf("strm%0d_dv", c), 32'(disp_rvalid), 1);
                chk($sformatf("strm%0d_dd", c), 32'(disp_rdata), 32'((c - 1) * 3));
            end
            if (c == 0) chk("strm0_dv", 32'(disp_rvalid), 0);
            if (c == 640) chk("strm_grant_rom", 32'(rom_addr), 'h100);
            if (c <= 640) chk($sformatf("strm%0d_done", c), 32'(cpu_done), 0);
            if (c == 641) chk("strm_done", 32'(cpu_done), 1);
            if (c == 642) chk("strm_crd", 32'(cpu_rdata), 'h300);
        end

        // C read during blanking
        ovr = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            drive(0, 0, c == 0, 'h10);
            #1;
            chk($sformatf("blk%0d_busy", c), 32'(cpu_busy), 32'(c == 1 || c == 2));
            chk($sformatf("blk%0d_done", c), 32'(cpu_done), 32'(c == 2));
            if (c == 1) chk("blk_rom", 32'(rom_addr), 'h10);
            if (c == 2) chk("blk_err", 32'(cpu_err), 0);
            if (c == 3) chk("blk_crd", 32'(cpu_rdata), 32'h00ABCDEF);
        end
        ovr = 1'b0;

        // Slot stealing: single idle display cycle 37 cycles after the request
        for (int c = 0; c <= 39; c++) begin
            @(negedge clk);
            drive(c != 37 && c != 39, 'h300 + c, c == 0, 'h155);
            #1;
            if (c <= 38) chk($sformatf("steal%0d_rom", c), 32'(rom_addr), (c == 37) ? 'h155 : 32'('h300 + c));
            if (c <= 38) chk($sformatf("steal%0d_done", c), 32'(cpu_done), 32'(c == 38));
            if (c == 38) chk("steal_dv_gap", 32'(disp_rvalid), 0);
            if (c == 39) begin
                chk("steal_dv", 32'(disp_rvalid), 1);
                chk("steal_dd", 32'(disp_rdata), 32'(('h300 + 38) * 3));
                chk("steal_crd", 32'(cpu_rdata), 'h3FF);
            end
        end

        // Asynchronous reset while waiting
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            drive(1, 5 + c, c == 0, 'h77);
        end
        #1;
        chk("arst_pre_busy", 32'(cpu_busy), 1);
        #1;
        disp_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(cpu_busy), 0);
        chk("arst_done", 32'(cpu_done), 0);
        chk("arst_dv", 32'(disp_rvalid), 0);
        chk("arst_crd", 32'(cpu_rdata), 0);
        chk("arst_rom", 32'(rom_addr), 0);
        @(posedge clk);
        #1;
        chk("arst_hold_done", 32'(cpu_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            drive(0, 0, c == 0, 'h21);
            #1;
            if (c == 1) chk("post_rom", 32'(rom_addr), 'h21);
            chk($sformatf("post%0d_done", c), 32'(cpu_done), 32'(c == 2));
            if (c == 3) chk("post_crd", 32'(cpu_rdata), 'h63);
            if (c == 3) chk("post_crd8", 32'(cpu_rdata_8), 'h63);
        end

        // Timeout on the TIMEOUT=8 instance, display held busy
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            drive(c <= 9, c, c == 0, 'h22);
            #1;
            if (c <= 9) begin
                chk($sformatf("tmo%0d_done8", c), 32'(cpu_done_8), 32'(c == 9));
                chk($sformatf("tmo%0d_tmo8", c), 32'(cpu_timeout_8), 32'(c == 9));
                chk($sformatf("tmo%0d_busy8", c), 32'(cpu_busy_8), 32'(c >= 1 && c <= 8));
                chk($sformatf("tmo%0d_done", c), 32'(cpu_done), 0);
            end
            if (c == 9) begin
                chk("tmo_err8", 32'(cpu_err_8), 0);
                chk("tmo_crd8", 32'(cpu_rdata_8), 'h63);
                chk("tmo_dv8", 32'(disp_rvalid_8), 1);
                chk("tmo_dd8", 32'(disp_rdata_8), 24);
            end
            if (c == 10) chk("tmo_crd8_after", 32'(cpu_rdata_8), 'h63);
            if (c == 11) chk("tmo_main_done", 32'(cpu_done), 1);
            if (c == 11) chk("tmo_main_tmo", 32'(cpu_timeout), 0);
        end

        // Grant in the cycle the counter would expire: no timeout
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            drive(c <= 9 && c != 8, c, c == 0, 'h23);
            #1;
            if (c == 8) chk("gw_rom8", 32'(rom_addr_8), 'h23);
            if (c <= 9) chk($sformatf("gw%0d_done8", c), 32'(cpu_done_8), 32'(c == 9));
            if (c == 9) chk("gw_tmo8", 32'(cpu_timeout_8), 0);
            if (c == 10) begin
                chk("gw_crd8", 32'(cpu_rdata_8), 'h69);
                chk("gw_busy8", 32'(cpu_busy_8), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
